// File: rtl/tdm_mux2.sv
`timescale 1ns/1ps
// tdm_mux2 -- two-input time-division multiplexer.
//
// Merges two independent valid/ready streams onto one output channel. Each
// word is tagged with its source index (out_sel). Every input has its own
// DEPTH-entry FIFO. A round-robin arbiter drains the FIFOs into a single
// registered output stage.
//
// Handshake: a word moves across any valid/ready pair on a rising clk edge
// where both valid and ready are high. A valid producer holds its data
// until that edge. Ready never depends combinationally on the partner's
// valid. The in*_ready signals depend only on registered FIFO state.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in0_data/valid/ready  channel 0 input stream
//   in1_data/valid/ready  channel 1 input stream
//   out_data/sel/valid    merged, registered output word and its source
//   out_ready             downstream accepts the output word
//   dbg_state             output-stage FSM state (0 = IDLE, 1 = LOADED)
module tdm_mux2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic {IDLE = 1'b0, LOADED = 1'b1} state_t;

  // FIFO storage and pointers; the extra pointer MSB separates full from empty.
  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];
  logic [AW:0]      wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;

  logic             empty0, empty1, full0, full1;
  logic             push0, push1, pop0, pop1;
  logic             load_en, grant1;
  logic [WIDTH-1:0] head0, head1;

  state_t           state;
  logic             last_sel;

  assign empty0 = (wr_ptr0 == rd_ptr0);
  assign empty1 = (wr_ptr1 == rd_ptr1);
  assign full0  = (wr_ptr0[AW] != rd_ptr0[AW]) && (wr_ptr0[AW-1:0] == rd_ptr0[AW-1:0]);
  assign full1  = (wr_ptr1[AW] != rd_ptr1[AW]) && (wr_ptr1[AW-1:0] == rd_ptr1[AW-1:0]);

  assign in0_ready = !full0;
  assign in1_ready = !full1;

  assign push0 = in0_valid && in0_ready;
  assign push1 = in1_valid && in1_ready;

  assign head0 = mem0[rd_ptr0[AW-1:0]];
  assign head1 = mem1[rd_ptr1[AW-1:0]];

  // The output register is free when empty or being consumed this edge.
  assign load_en = !out_valid || out_ready;

  // Channel 1 wins when it is the only one with data. It also wins on
  // contention when channel 0 was served last.
  assign grant1 = !empty1 && (empty0 || !last_sel);
  assign pop1   = load_en && grant1;
  assign pop0   = load_en && !empty0 && !grant1;

  assign dbg_state = (state == LOADED);

  // Storage is not reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push0) mem0[wr_ptr0[AW-1:0]] <= in0_data;
    if (push1) mem1[wr_ptr1[AW-1:0]] <= in1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr0 <= '0;
      rd_ptr0 <= '0;
      wr_ptr1 <= '0;
      rd_ptr1 <= '0;
    end else begin
      if (push0) wr_ptr0 <= wr_ptr0 + PTR_ONE;
      if (pop0)  rd_ptr0 <= rd_ptr0 + PTR_ONE;
      if (push1) wr_ptr1 <= wr_ptr1 + PTR_ONE;
      if (pop1)  rd_ptr1 <= rd_ptr1 + PTR_ONE;
    end
  end

  // Output stage FSM. out_valid mirrors LOADED but is kept as its own
  // register so the port is driven straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
      last_sel  <= 1'b1;  // channel 0 wins the first contention
    end else if (load_en) begin
      if (pop0 || pop1) begin
        state     <= LOADED;
        out_valid <= 1'b1;
        out_data  <= grant1 ? head1 : head0;
        out_sel   <= grant1;
        last_sel  <= grant1;
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux2.sv
`timescale 1ns/1ps
module tb_tdm_mux2;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         in0_valid, in0_ready, in1_valid, in1_ready;
  logic         out_sel, out_valid, out_ready, dbg_state;

  // Per-channel expected data, plus an optional expected out_sel order
  // for directed tests whose interleaving is known in advance.
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  logic         exp_sel_q[$];

  int checks = 0;
  int passes = 0;

  tdm_mux2 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got event-missing expected event-present", name);
  endtask

  // ---------------- input monitor: record accepted words ----------------
  // Inputs change 1ns after posedge, so negedge values are the ones the
  // next posedge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in0_valid && in0_ready) exp0_q.push_back(in0_data);
      if (in1_valid && in1_ready) exp1_q.push_back(in1_data);
    end
  end

  // ---------------- output monitor: scoreboard ----------------
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_sel   = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, prev_data);
        check("stall_sel_hold", out_sel, prev_sel);
      end
      if (out_valid && out_ready) begin
        if (exp_sel_q.size() != 0) check("out_sel_order", out_sel, exp_sel_q.pop_front());
        if (!out_sel) begin
          if (exp0_q.size() == 0) fail_now("unexpected_ch0_word");
          else check("ch0_data", out_data, exp0_q.pop_front());
        end else begin
          if (exp1_q.size() == 0) fail_now("unexpected_ch1_word");
          else check("ch1_data", out_data, exp1_q.pop_front());
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_sel   = out_sel;
    end
  end

  // ---------------- driver tasks ----------------
  // Called 1ns after a posedge; returns 1ns after the accepting edge with
  // valid still high so back-to-back sends stream without bubbles.
  task automatic send0(input logic [W-1:0] d);
    int n;
    in0_valid = 1'b1;
    in0_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in0_ready && n < 200);
    if (!in0_ready) fail_now("send0_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp0_q.size() != 0 || exp1_q.size() != 0 || out_valid) && n < 300);
    check(name, exp0_q.size() + exp1_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic push_sel(input logic s, input int n);
    for (int i = 0; i < n; i++) exp_sel_q.push_back(s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_in0_ready", in0_ready, 1);
    check("rst_in1_ready", in1_ready, 1);
    check("rst_dbg_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("idle_after_rst", out_valid, 0);

    // Single channel: 0x11,0x22,0x33 on in1, first out_valid one edge later
    out_ready = 1'b1;
    push_sel(1'b1, 3);
    in1_valid = 1'b1;
    in1_data  = 8'h11;
    @(posedge clk); #1;
    check("lat_not_yet", out_valid, 0);
    in1_data = 8'h22;
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'h11);
    check("lat_sel", out_sel, 1);
    in1_data = 8'h33;
    @(posedge clk); #1;
    in1_valid = 1'b0;
    check("single_2nd", out_data, 8'h22);
    @(posedge clk); #1;
    check("single_3rd", out_data, 8'h33);
    wait_drain("single_drain");

    // Contention: both FIFOs loaded while stalled, then drained alternately
    out_ready = 1'b0;
    push_sel(1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      in0_valid = 1'b1;
      in0_data  = 8'hA0 + W'(i);
      in1_valid = 1'b1;
      in1_data  = 8'hB0 + W'(i);
      if (i < 3) push_sel(1'b1, 1);
      if (i < 3) push_sel(1'b0, 1);
      @(posedge clk); #1;
    end
    push_sel(1'b1, 1);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    check("cont_in1_full", in1_ready, 0);
    check("cont_in0_notfull", in0_ready, 1);
    check("cont_head", out_data, 8'hA0);
    out_ready = 1'b1;
    wait_drain("cont_drain");

    // Backpressure: 5 words fit (4 FIFO + output register), then ready drops
    out_ready = 1'b0;
    push_sel(1'b0, 5);
    for (int i = 0; i < 5; i++) send0(8'hC0 + W'(i));
    in0_valid = 1'b0;
    @(negedge clk);
    check("bp_in0_full", in0_ready, 0);
    check("bp_in1_ready", in1_ready, 1);
    check("bp_out_valid", out_valid, 1);
    check("bp_dbg_state", dbg_state, 1);
    check("bp_out_data", out_data, 8'hC0);
    repeat (3) @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_ready_back", in0_ready, 1);

    // Full FIFO with a producer pushing continuously while it drains
    out_ready = 1'b0;
    push_sel(1'b0, 9);
    for (int i = 0; i < 5; i++) send0(8'hD0 + W'(i));
    in0_data  = 8'hD5;
    out_ready = 1'b1;
    @(negedge clk);
    check("full_push_blocked", in0_ready, 0);
    @(posedge clk); #1;
    for (int i = 5; i < 9; i++) send0(8'hD0 + W'(i));
    in0_valid = 1'b0;
    wait_drain("full_pp_drain");

    // Pointer wrap: 3*DEPTH+1 words through channel 0
    push_sel(1'b0, 3 * D + 1);
    for (int i = 0; i < 3 * D + 1; i++) send0(8'h40 + W'(i));
    in0_valid = 1'b0;
    wait_drain("wrap_drain");
    check("wrap_in0_ready", in0_ready, 1);

    // Random valids and out_ready; per-channel order checked by scoreboard
    for (int c = 0; c < 1000; c++) begin
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      in0_data  = W'($urandom_range(0, 255));
      in1_data  = W'($urandom_range(0, 255));
      out_ready = (c < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain");

    // Reset mid-stream with 3 words buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send0(8'h70 + W'(i));
    in0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_sel", out_sel, 0);
    check("mid_rst_in0_ready", in0_ready, 1);
    check("mid_rst_in1_ready", in1_ready, 1);
    exp0_q.delete();
    exp1_q.delete();
    exp_sel_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("post_rst_idle", out_valid, 0);
    check("post_rst_in0_ready", in0_ready, 1);

    check("final_sel_q_empty", exp_sel_q.size(), 0);
    check("final_data_q_empty", exp0_q.size() + exp1_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
